// File: rtl/peridot_cfg_pkg.sv
// Shared state types, command-byte field layout and response encoding for the
// PERIDOT configuration layer.
package peridot_cfg_pkg;

  localparam logic [7:0]  ESC_DEFAULT  = 8'h3A;

  localparam int unsigned CMD_W_BIT    = 7;
  localparam int unsigned CMD_ADDR_MSB = 6;
  localparam int unsigned CMD_ADDR_LSB = 4;
  localparam int unsigned CMD_NIB_MSB  = 3;
  localparam int unsigned CMD_NIB_LSB  = 0;
  localparam int unsigned ADDR_W       = CMD_ADDR_MSB - CMD_ADDR_LSB + 1;
  localparam int unsigned NIB_W        = CMD_NIB_MSB - CMD_NIB_LSB + 1;

  typedef enum logic {
    U_PASS,
    U_CMD
  } u_state_t;

  typedef enum logic [1:0] {
    D_IDLE,
    D_LIT,
    D_RESP
  } d_state_t;

  // Response byte sent back to the host after a command: {W, addr, nibble}.
  function automatic logic [7:0] resp_byte(input logic              w,
                                           input logic [ADDR_W-1:0] addr,
                                           input logic [NIB_W-1:0]  nib);
    return {w, addr, nib};
  endfunction

endpackage

// File: rtl/peridot_cfg_respfifo.sv
// Show-ahead synchronous FIFO queuing command responses for the downstream merger.
// A push while full is accepted when a pop happens in the same cycle.
module peridot_cfg_respfifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // Pointers wrap modulo DEPTH since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/peridot_config_ng.sv
// PERIDOT config-layer stream processor: strips escaped commands from rx, runs them
// on the nibble register bank and merges escaped responses into tx ahead of packet
// traffic. Optional escape timeout: define PERIDOT_CFG_TIMEOUT_EN.
module peridot_config_ng
  import peridot_cfg_pkg::*;
#(
  parameter logic [7:0]  ESC_CODE       = ESC_DEFAULT,
  parameter int unsigned NUM_REGS       = 4,
  parameter int unsigned RESP_DEPTH     = 4,
  parameter logic [31:0] CFG_INIT       = 32'h0,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  rx_ready,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  input  logic                  b2p_ready,
  output logic                  b2p_valid,
  output logic [7:0]            b2p_data,
  output logic                  p2b_ready,
  input  logic                  p2b_valid,
  input  logic [7:0]            p2b_data,
  input  logic                  tx_ready,
  output logic                  tx_valid,
  output logic [7:0]            tx_data,
  output logic [NUM_REGS*4-1:0] cfg_out,
  input  logic [NUM_REGS*4-1:0] cfg_in,
  output logic [NUM_REGS-1:0]   cfg_wstrobe,
  output logic                  esc_error
);

  localparam int unsigned CFG_W = NUM_REGS * NIB_W;
  localparam int unsigned AC_W  = ADDR_W + 1;

  u_state_t          u_state, u_state_n;
  d_state_t          d_state, d_state_n;
  logic              slot_free, rx_hs, b2p_load;
  logic              cmd_w, addr_ok, cfg_we, err_c;
  logic [ADDR_W-1:0] cmd_addr;
  logic [NIB_W-1:0]  cmd_nib, rd_nib;
  logic              q_push, q_pop, q_full, q_empty;
  logic [7:0]        q_wdata, q_rdata;
  logic              tx_load, hold_load;
  logic [7:0]        tx_load_data, resp_hold;

  assign cmd_w    = rx_data[CMD_W_BIT];
  assign cmd_addr = rx_data[CMD_ADDR_MSB:CMD_ADDR_LSB];
  assign cmd_nib  = rx_data[CMD_NIB_MSB:CMD_NIB_LSB];
  assign addr_ok  = AC_W'(cmd_addr) < AC_W'(NUM_REGS);

  assign slot_free = !b2p_valid || b2p_ready;
  assign rx_ready  = slot_free && ((u_state == U_PASS) || !q_full);
  assign rx_hs     = rx_valid && rx_ready;

  always_comb begin
    rd_nib = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (cmd_addr == ADDR_W'(i)) rd_nib = cfg_in[i*NIB_W +: NIB_W];
    end
  end

  assign q_wdata = resp_byte(cmd_w, cmd_addr, cmd_w ? cmd_nib : rd_nib);

`ifdef PERIDOT_CFG_TIMEOUT_EN
  localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TO_W-1:0] to_cnt;
  logic            to_expired;

  assign to_expired = (u_state == U_CMD) && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  // Idle time spent waiting for the command byte after an ESC.
  always_ff @(posedge clk) begin
    if (reset || (u_state != U_CMD) || rx_hs || to_expired) to_cnt <= '0;
    else                                                     to_cnt <= to_cnt + TO_W'(1);
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) u_state <= U_PASS;
    else       u_state <= u_state_n;
  end

  always_comb begin
    u_state_n = u_state;
    b2p_load  = 1'b0;
    q_push    = 1'b0;
    cfg_we    = 1'b0;
    err_c     = 1'b0;
    case (u_state)
      U_PASS: begin
        if (rx_hs) begin
          if (rx_data == ESC_CODE) u_state_n = U_CMD;
          else                     b2p_load  = 1'b1;
        end
      end
      U_CMD: begin
        if (rx_hs) begin
          u_state_n = U_PASS;
          if (rx_data == ESC_CODE) b2p_load = 1'b1;
          else if (!addr_ok)       err_c    = 1'b1;
          else begin
            q_push = 1'b1;
            cfg_we = cmd_w;
          end
        end
`ifdef PERIDOT_CFG_TIMEOUT_EN
        else if (to_expired) begin
          u_state_n = U_PASS;
          err_c     = 1'b1;
        end
`endif
      end
      default: u_state_n = U_PASS;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      b2p_valid   <= 1'b0;
      b2p_data    <= '0;
      cfg_out     <= CFG_INIT[CFG_W-1:0];
      cfg_wstrobe <= '0;
      esc_error   <= 1'b0;
    end else begin
      if (b2p_load) begin
        b2p_valid <= 1'b1;
        b2p_data  <= rx_data;
      end else if (b2p_ready) begin
        b2p_valid <= 1'b0;
      end
      esc_error   <= err_c;
      cfg_wstrobe <= '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (cfg_we && (cmd_addr == ADDR_W'(i))) begin
          cfg_out[i*NIB_W +: NIB_W] <= cmd_nib;
          cfg_wstrobe[i]            <= 1'b1;
        end
      end
    end
  end

  peridot_cfg_respfifo #(
    .DEPTH (RESP_DEPTH),
    .WIDTH (8)
  ) u_respfifo (
    .clk   (clk),
    .reset (reset),
    .push  (q_push),
    .wdata (q_wdata),
    .pop   (q_pop),
    .rdata (q_rdata),
    .full  (q_full),
    .empty (q_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) d_state <= D_IDLE;
    else       d_state <= d_state_n;
  end

  // Responses win over packet bytes; each escaped pair is emitted back to back.
  always_comb begin
    d_state_n    = d_state;
    tx_load      = 1'b0;
    tx_load_data = ESC_CODE;
    q_pop        = 1'b0;
    hold_load    = 1'b0;
    p2b_ready    = 1'b0;
    if (!tx_valid || tx_ready) begin
      case (d_state)
        D_IDLE: begin
          if (!q_empty) begin
            q_pop     = 1'b1;
            hold_load = 1'b1;
            tx_load   = 1'b1;
            d_state_n = D_RESP;
          end else if (p2b_valid) begin
            p2b_ready    = 1'b1;
            tx_load      = 1'b1;
            tx_load_data = p2b_data;
            if (p2b_data == ESC_CODE) d_state_n = D_LIT;
          end else begin
            p2b_ready = 1'b1;
          end
        end
        D_LIT: begin
          tx_load   = 1'b1;
          d_state_n = D_IDLE;
        end
        D_RESP: begin
          tx_load      = 1'b1;
          tx_load_data = resp_hold;
          d_state_n    = D_IDLE;
        end
        default: d_state_n = D_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_valid  <= 1'b0;
      tx_data   <= '0;
      resp_hold <= '0;
    end else begin
      if (tx_load) begin
        tx_valid <= 1'b1;
        tx_data  <= tx_load_data;
      end else if (tx_ready) begin
        tx_valid <= 1'b0;
      end
      if (hold_load) resp_hold <= q_rdata;
    end
  end

endmodule

// File: tb/tb_peridot_config_ng.sv
// Self-checking bench for peridot_config_ng: directed scenarios plus a randomized run
// checked against a stream-level model of the escape protocol.
module tb_peridot_config_ng;

  localparam logic [7:0]  ESC   = 8'h3A;
  localparam int unsigned NREGS = 4;
  localparam int unsigned DEPTH = 2;
  localparam logic [31:0] INIT  = 32'h0000_9C63;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_ready, rx_valid;
  logic [7:0]  rx_data;
  logic        b2p_ready, b2p_valid;
  logic [7:0]  b2p_data;
  logic        p2b_ready, p2b_valid;
  logic [7:0]  p2b_data;
  logic        tx_ready, tx_valid;
  logic [7:0]  tx_data;
  logic [15:0] cfg_out, cfg_in;
  logic [3:0]  cfg_wstrobe;
  logic        esc_error;

  int n_total = 0;
  int n_bad   = 0;

  peridot_config_ng #(
    .ESC_CODE       (ESC),
    .NUM_REGS       (NREGS),
    .RESP_DEPTH     (DEPTH),
    .CFG_INIT       (INIT),
    .TIMEOUT_CYCLES (1000)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_ready    (rx_ready),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .b2p_ready   (b2p_ready),
    .b2p_valid   (b2p_valid),
    .b2p_data    (b2p_data),
    .p2b_ready   (p2b_ready),
    .p2b_valid   (p2b_valid),
    .p2b_data    (p2b_data),
    .tx_ready    (tx_ready),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .cfg_out     (cfg_out),
    .cfg_in      (cfg_in),
    .cfg_wstrobe (cfg_wstrobe),
    .esc_error   (esc_error)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h @%0t", tag, got, want, $time);
    end
  endtask

  // Reference model state: expected streams and register bank.
  logic [7:0]  b2p_q[$];
  logic [7:0]  resp_q[$];
  logic [7:0]  p2b_q[$];
  logic [7:0]  tx_log[$];
  logic [7:0]  want_q[$];
  logic [15:0] m_cfg;
  logic [3:0]  exp_wstb;
  logic        exp_err, exp_b2p_v;
  logic        model_live = 1'b0;
  logic        m_cmd, txd_esc, m_load;
  logic        rx_hs_seen = 1'b0, p2b_hs_seen = 1'b0;
  int          ma;

  task automatic tx_literal(input logic [7:0] b);
    if (p2b_q.size() == 0) check_eq("tx_extra_lit", 32'(b), 32'hFFFF_FFFF);
    else                   check_eq("tx_lit", 32'(b), 32'(p2b_q.pop_front()));
  endtask

  always @(negedge clk) begin
    if (model_live) begin
      check_eq("cfg_out",     32'(cfg_out),     32'(m_cfg));
      check_eq("cfg_wstrobe", 32'(cfg_wstrobe), 32'(exp_wstb));
      check_eq("esc_error",   32'(esc_error),   32'(exp_err));
      check_eq("b2p_valid",   32'(b2p_valid),   32'(exp_b2p_v));
    end
    exp_wstb = '0;
    exp_err  = 1'b0;
    if (reset) begin
      m_cfg       = 16'(INIT);
      m_cmd       = 1'b0;
      txd_esc     = 1'b0;
      exp_b2p_v   = 1'b0;
      rx_hs_seen  = 1'b0;
      p2b_hs_seen = 1'b0;
      b2p_q.delete();
      resp_q.delete();
      p2b_q.delete();
      model_live  = 1'b1;
    end else begin
      m_load = 1'b0;
      if (b2p_valid && b2p_ready) begin
        if (b2p_q.size() == 0) check_eq("b2p_extra", 32'(b2p_data), 32'hFFFF_FFFF);
        else                   check_eq("b2p_data", 32'(b2p_data), 32'(b2p_q.pop_front()));
      end
      if (tx_valid && tx_ready) begin
        tx_log.push_back(tx_data);
        if (!txd_esc) begin
          if (tx_data == ESC) txd_esc = 1'b1;
          else                tx_literal(tx_data);
        end else begin
          txd_esc = 1'b0;
          if (tx_data == ESC)         tx_literal(tx_data);
          else if (resp_q.size() == 0) check_eq("tx_extra_resp", 32'(tx_data), 32'hFFFF_FFFF);
          else                         check_eq("tx_resp", 32'(tx_data), 32'(resp_q.pop_front()));
        end
      end
      p2b_hs_seen = p2b_valid && p2b_ready;
      if (p2b_hs_seen) p2b_q.push_back(p2b_data);
      rx_hs_seen = rx_valid && rx_ready;
      if (rx_hs_seen) begin
        if (!m_cmd) begin
          if (rx_data == ESC) m_cmd = 1'b1;
          else begin
            b2p_q.push_back(rx_data);
            m_load = 1'b1;
          end
        end else begin
          m_cmd = 1'b0;
          ma    = int'(rx_data[6:4]);
          if (rx_data == ESC) begin
            b2p_q.push_back(rx_data);
            m_load = 1'b1;
          end else if (ma >= NREGS) begin
            exp_err = 1'b1;
          end else if (rx_data[7]) begin
            m_cfg[ma*4 +: 4] = rx_data[3:0];
            exp_wstb[ma]     = 1'b1;
            resp_q.push_back(rx_data);
          end else begin
            resp_q.push_back({1'b0, rx_data[6:4], cfg_in[ma*4 +: 4]});
          end
        end
      end
      exp_b2p_v = m_load || (b2p_valid && !b2p_ready);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) step();
  endtask

  task automatic send_rx(input logic [7:0] b, output int waits);
    rx_valid = 1'b1;
    rx_data  = b;
    waits    = 0;
    @(negedge clk);
    while (!rx_ready && waits < 200) begin
      waits++;
      @(negedge clk);
    end
    if (!rx_ready) check_eq("rx_accept_timeout", 32'(rx_ready), 32'd1);
    step();
    rx_valid = 1'b0;
  endtask

  task automatic send_p2b(input logic [7:0] b);
    int waits = 0;
    p2b_valid = 1'b1;
    p2b_data  = b;
    @(negedge clk);
    while (!p2b_ready && waits < 200) begin
      waits++;
      @(negedge clk);
    end
    if (!p2b_ready) check_eq("p2b_accept_timeout", 32'(p2b_ready), 32'd1);
    step();
    p2b_valid = 1'b0;
  endtask

  task automatic check_log(input string tag);
    check_eq({tag, "_len"}, 32'(tx_log.size()), 32'(want_q.size()));
    for (int i = 0; i < want_q.size() && i < tx_log.size(); i++)
      check_eq(tag, 32'(tx_log[i]), 32'(want_q[i]));
  endtask

  initial begin
    int          w;
    int          hi;
    logic [15:0] rnd_cfg;
    reset     = 1'b1;
    rx_valid  = 1'b0;
    rx_data   = '0;
    b2p_ready = 1'b1;
    p2b_valid = 1'b0;
    p2b_data  = '0;
    tx_ready  = 1'b1;
    cfg_in    = 16'h7CC1;
    wait_cycles(3);
    reset = 1'b0;
    @(negedge clk);
    check_eq("rst_b2p_valid", 32'(b2p_valid),   32'd0);
    check_eq("rst_tx_valid",  32'(tx_valid),    32'd0);
    check_eq("rst_cfg_out",   32'(cfg_out),     32'h9C63);
    check_eq("rst_wstrobe",   32'(cfg_wstrobe), 32'd0);
    check_eq("rst_esc_error", 32'(esc_error),   32'd0);
    check_eq("rst_rx_ready",  32'(rx_ready),    32'd1);
    check_eq("rst_p2b_ready", 32'(p2b_ready),   32'd1);
    step();

    // Pass-through with an escaped literal, no stalls.
    send_rx(8'h41, w); check_eq("pt_stall0", 32'(w), 32'd0);
    send_rx(8'h3A, w); check_eq("pt_stall1", 32'(w), 32'd0);
    send_rx(8'h3A, w); check_eq("pt_stall2", 32'(w), 32'd0);
    send_rx(8'h42, w); check_eq("pt_stall3", 32'(w), 32'd0);
    wait_cycles(4);
    check_eq("pt_drained", 32'(b2p_q.size()), 32'd0);

    // Write reg2 <= 5.
    send_rx(8'h3A, w);
    send_rx(8'hA5, w);
    @(negedge clk);
    check_eq("wr_strobe", 32'(cfg_wstrobe), 32'h4);
    check_eq("wr_nibble", 32'(cfg_out[11:8]), 32'h5);
    wait_cycles(10);

    // Read reg1 with tx idle: ESC at N+2, response at N+3.
    tx_log.delete();
    send_rx(8'h3A, w);
    send_rx(8'h1F, w);
    @(negedge clk);
    check_eq("rd_lat_n1_valid", 32'(tx_valid), 32'd0);
    @(negedge clk);
    check_eq("rd_lat_n2", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'h3A});
    @(negedge clk);
    check_eq("rd_lat_n3", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'h1C});
    wait_cycles(4);

    // Invalid address, then normal traffic.
    send_rx(8'h3A, w);
    send_rx(8'hF0, w);
    @(negedge clk);
    check_eq("bad_addr_err", 32'(esc_error), 32'd1);
    step();
    send_rx(8'h55, w);
    wait_cycles(8);
    check_eq("bad_addr_no_resp", 32'(resp_q.size()), 32'd0);
    check_eq("bad_addr_pass",    32'(b2p_q.size()),  32'd0);

    // Pending response goes ahead of packet bytes; pairs stay intact.
    cfg_in = 16'h7C21;
    tx_log.delete();
    send_rx(8'h3A, w);
    send_rx(8'h13, w);
    send_p2b(8'h10);
    send_p2b(8'h3A);
    send_p2b(8'h11);
    wait_cycles(10);
    want_q = '{8'h3A, 8'h12, 8'h10, 8'h3A, 8'h3A, 8'h11};
    check_log("merge_order");

    // Queue fills while tx is stalled; the next command is held, not dropped.
    tx_ready = 1'b0;
    tx_log.delete();
    hi = 0;
    send_rx(8'h3A, w); hi += w;
    send_rx(8'h00, w); hi += w;
    send_rx(8'h3A, w); hi += w;
    send_rx(8'h10, w); hi += w;
    send_rx(8'h3A, w); hi += w;
    send_rx(8'h20, w); hi += w;
    check_eq("fill_no_stall", 32'(hi), 32'd0);
    send_rx(8'h3A, w);
    rx_valid = 1'b1;
    rx_data  = 8'h30;
    hi = 0;
    repeat (6) begin
      @(negedge clk);
      if (rx_ready) hi++;
    end
    check_eq("full_stall", 32'(hi), 32'd0);
    step();
    tx_ready = 1'b1;
    w = 0;
    @(negedge clk);
    while (!rx_ready && w < 50) begin
      w++;
      @(negedge clk);
    end
    check_eq("full_release", 32'(rx_ready), 32'd1);
    step();
    rx_valid = 1'b0;
    wait_cycles(20);
    want_q = '{8'h3A, 8'h01, 8'h3A, 8'h12, 8'h3A, 8'h2C, 8'h3A, 8'h37};
    check_log("full_order");

    // Randomized traffic with a reset in the middle.
    for (int c = 0; c < 4000; c++) begin
      reset = (c >= 1500 && c < 1503);
      if (!rx_valid || rx_hs_seen) begin
        rx_valid = ($urandom_range(0, 3) != 0);
        rx_data  = ($urandom_range(0, 9) < 3) ? ESC : 8'($urandom);
      end
      if (!p2b_valid || p2b_hs_seen) begin
        p2b_valid = ($urandom_range(0, 2) == 0);
        p2b_data  = ($urandom_range(0, 4) == 0) ? ESC : 8'($urandom);
      end
      b2p_ready = ($urandom_range(0, 3) != 0);
      tx_ready  = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) begin
        rnd_cfg = 16'($urandom);
        if (rnd_cfg[15:12] == 4'hA) rnd_cfg[15:12] = 4'h5;
        cfg_in = rnd_cfg;
      end
      step();
    end
    reset     = 1'b0;
    rx_valid  = 1'b0;
    p2b_valid = 1'b0;
    b2p_ready = 1'b1;
    tx_ready  = 1'b1;
    wait_cycles(40);
    check_eq("end_b2p_left",  32'(b2p_q.size()),  32'd0);
    check_eq("end_resp_left", 32'(resp_q.size()), 32'd0);
    check_eq("end_p2b_left",  32'(p2b_q.size()),  32'd0);
    check_eq("end_tx_pair",   32'(txd_esc),       32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
